// File: rtl/alu_sequencer.sv
// Two-button 3-bit ALU sequencer: btn1 increments the selected field, btn2 advances the state.
// Define AUTO_CYCLE_EN to make the SHOW state step through the ops every SHOW_CYCLES cycles.
module alu_sequencer #(
  parameter int unsigned DB_CNT      = 240000,
  parameter int unsigned SHOW_CYCLES = 24000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  output logic [2:0] led,
  output logic [1:0] mode
);

  localparam int unsigned DbW = $clog2(DB_CNT + 1);

  localparam logic [1:0] StSelA  = 2'd0;
  localparam logic [1:0] StSelB  = 2'd1;
  localparam logic [1:0] StSelOp = 2'd2;
  localparam logic [1:0] StShow  = 2'd3;

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpAnd = 2'd2;

  if (DB_CNT == 0 || SHOW_CYCLES == 0) begin : g_param_check
    $error("alu_sequencer: DB_CNT and SHOW_CYCLES must be non-zero");
  end

  // Bit 0 tracks btn1, bit 1 tracks btn2.
  logic [1:0]     sync1_q, sync2_q, db_q, press_q;
  logic [DbW-1:0] db_cnt_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      db_q    <= 2'b11;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {btn2, btn1};
      sync2_q <= sync1_q;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DbW'(DB_CNT - 1)) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
            press_q[i]  <= ~sync2_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic [1:0] state_q, state_d;
  logic [2:0] a_q, a_d, b_q, b_d, c, disp;
  logic [1:0] op_q, op_d;

`ifdef AUTO_CYCLE_EN
  localparam int unsigned SwW = $clog2(SHOW_CYCLES + 1);
  logic [SwW-1:0] show_cnt_q, show_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    // btn2 wins when both events land in the same cycle.
    if (press_q[1]) begin
      case (state_q)
        StSelA:  state_d = StSelB;
        StSelB:  state_d = StSelOp;
        StSelOp: state_d = StShow;
        default: state_d = StSelA;
      endcase
    end else if (press_q[0]) begin
      case (state_q)
        StSelA:  a_d  = a_q + 3'd1;
        StSelB:  b_d  = b_q + 3'd1;
        StSelOp: op_d = op_q + 2'd1;
        default: ;
      endcase
    end
`ifdef AUTO_CYCLE_EN
    // Held at zero outside SHOW so every entry starts a fresh period.
    show_cnt_d = '0;
    if (state_q == StShow) begin
      if (show_cnt_q == SwW'(SHOW_CYCLES - 1)) begin
        op_d = op_q + 2'd1;
      end else begin
        show_cnt_d = show_cnt_q + SwW'(1);
      end
    end
`endif
  end

  always_comb begin
    case (op_q)
      OpAdd:   c = a_q + b_q;
      OpSub:   c = a_q - b_q;
      OpAnd:   c = a_q & b_q;
      default: c = a_q | b_q;
    endcase
    case (state_q)
      StSelA:  disp = a_q;
      StSelB:  disp = b_q;
      StSelOp: disp = {1'b0, op_q};
      default: disp = c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSelA;
      a_q     <= 3'b010;
      b_q     <= 3'b011;
      op_q    <= OpAdd;
      led     <= 3'b111;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      led     <= ~disp;
    end
  end

`ifdef AUTO_CYCLE_EN
  always_ff @(posedge clk) begin
    if (rst) show_cnt_q <= '0;
    else     show_cnt_q <= show_cnt_d;
  end
`endif

  assign mode = state_q;

endmodule
